// File: rtl/gated_clock_div_prog_if.sv
// Configuration port bundle for gated_clock_div_prog.
//
// Handshake: the slave drives CFG_RDY high while its shadow slot is free.
// A write happens on a CLK_IN rising edge where CFG_EN=1 and CFG_RDY=1, and
// DIV_IN/HIGH_IN are sampled on that edge. CFG_EN while CFG_RDY=0 has no
// effect. CFG_ERR is a sticky status bit. It is set by a rejected write and
// cleared by the next accepted write.
interface gated_clock_div_prog_if #(
  parameter int width = 4
) ();
  logic [width-1:0] DIV_IN;
  logic [width-1:0] HIGH_IN;
  logic             CFG_EN;
  logic             CFG_RDY;
  logic             CFG_ERR;

  modport master (
    output DIV_IN,
    output HIGH_IN,
    output CFG_EN,
    input  CFG_RDY,
    input  CFG_ERR
  );

  modport slave (
    input  DIV_IN,
    input  HIGH_IN,
    input  CFG_EN,
    output CFG_RDY,
    output CFG_ERR
  );
endinterface

// File: rtl/gated_clock_div_prog.sv
// Gated clock divider with a programmable period and high time.
// CLK_OUT is high for the last high_r counts of every div_r-count period.
// A clock-low transparent latch gates it, so gate changes never cut a pulse short.
// PREEDGE flags the CLK_IN cycle just before each CLK_OUT rising edge.
// New settings are staged in a shadow slot and applied only at the period wrap.
// Optional build macro: GATED_CLOCK_DIV_PROG_FREEZE_EN. When it is defined,
// the phase counter stops during the low phase while the gate is closed.
module gated_clock_div_prog #(
  parameter int width    = 4,
  parameter int DEF_DIV  = 3,
  parameter int DEF_HIGH = 1,
  parameter int OFFSET   = 0
) (
  input  logic                 CLK_IN,
  input  logic                 RST,
  input  logic                 CLK_GATE_IN,
  gated_clock_div_prog_if.slave cfg,
  output logic                 PREEDGE,
  output logic                 CLK_OUT,
  output logic                 CLK_GATE_OUT
);

  // Reset phase: OFFSET counts before the count that precedes the first high cycle.
  localparam logic [width-1:0] RST_CNTR = width'(DEF_DIV - DEF_HIGH - 1 - OFFSET);
  localparam logic [width-1:0] RST_DIV  = width'(DEF_DIV);
  localparam logic [width-1:0] RST_HIGH = width'(DEF_HIGH);
  localparam logic [width-1:0] ONE      = width'(1);
  localparam logic [width-1:0] TWO      = width'(2);

  logic [width-1:0] cntr_q, cntr_d;
  logic [width-1:0] div_q, div_d;
  logic [width-1:0] high_q, high_d;
  logic [width-1:0] pend_div_q, pend_div_d;
  logic [width-1:0] pend_high_q, pend_high_d;
  logic             pend_v_q, pend_v_d;
  logic             err_q, err_d;
  logic             new_gate_q;

  logic [width-1:0] low_len;
  logic             clk_div;
  logic             at_wrap;
  logic             cfg_wr;
  logic             cfg_legal;
  logic             hold;

  assign low_len   = div_q - high_q;
  assign clk_div   = (cntr_q >= low_len);
  assign at_wrap   = (cntr_q == (div_q - ONE));
  assign cfg_wr    = cfg.CFG_EN & ~pend_v_q;
  assign cfg_legal = (cfg.DIV_IN >= TWO) && (cfg.HIGH_IN >= ONE) && (cfg.HIGH_IN < cfg.DIV_IN);

`ifdef GATED_CLOCK_DIV_PROG_FREEZE_EN
  // The low phase is frozen while the gate is closed, so the first pulse after reopening is full width.
  assign hold = ~new_gate_q & ~clk_div;
`else
  assign hold = 1'b0;
`endif

  // Next state: advance or wrap the counter, apply pending settings at the wrap, accept config writes.
  always_comb begin
    cntr_d      = cntr_q;
    div_d       = div_q;
    high_d      = high_q;
    pend_div_d  = pend_div_q;
    pend_high_d = pend_high_q;
    pend_v_d    = pend_v_q;
    err_d       = err_q;
    if (hold) begin
      cntr_d = cntr_q;
    end else if (at_wrap) begin
      cntr_d = '0;
      if (pend_v_q) begin
        div_d    = pend_div_q;
        high_d   = pend_high_q;
        pend_v_d = 1'b0;
      end
    end else begin
      cntr_d = cntr_q + ONE;
    end
    // cfg_wr requires the slot to be empty, so it never coincides with an apply.
    if (cfg_wr) begin
      if (cfg_legal) begin
        pend_div_d  = cfg.DIV_IN;
        pend_high_d = cfg.HIGH_IN;
        pend_v_d    = 1'b1;
        err_d       = 1'b0;
      end else begin
        err_d = 1'b1;
      end
    end
  end

  // Divider state registers. Reset restores the default settings and discards any pending write.
  always_ff @(posedge CLK_IN or negedge RST) begin
    if (!RST) begin
      cntr_q      <= RST_CNTR;
      div_q       <= RST_DIV;
      high_q      <= RST_HIGH;
      pend_div_q  <= RST_DIV;
      pend_high_q <= RST_HIGH;
      pend_v_q    <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      cntr_q      <= cntr_d;
      div_q       <= div_d;
      high_q      <= high_d;
      pend_div_q  <= pend_div_d;
      pend_high_q <= pend_high_d;
      pend_v_q    <= pend_v_d;
      err_q       <= err_d;
    end
  end

  // Gate latch: open while CLK_OUT is low and closed while CLK_OUT is high. Reset closes the gate.
  always_latch begin
    if (!RST) begin
      new_gate_q <= 1'b0;
    end else if (!(clk_div & new_gate_q)) begin
      new_gate_q <= CLK_GATE_IN;
    end
  end

  // Early rise indication. At a wrap with a load due, it is judged against the incoming settings.
  always_comb begin
    PREEDGE = 1'b0;
    if (!RST || hold) begin
      PREEDGE = 1'b0;
    end else if (pend_v_q && at_wrap) begin
      PREEDGE = ((pend_div_q - pend_high_q) == ONE);
    end else begin
      PREEDGE = (cntr_q == (low_len - ONE));
    end
  end

  assign CLK_OUT      = clk_div & new_gate_q;
  assign CLK_GATE_OUT = new_gate_q;
  assign cfg.CFG_RDY  = ~pend_v_q;
  assign cfg.CFG_ERR  = err_q;

endmodule

// File: tb/tb_gated_clock_div_prog.sv
// Directed bench for gated_clock_div_prog.
// u0 is a (3,1) instance with OFFSET=0. It is reprogrammed and gated.
// u1 is a (3,1) instance with OFFSET=1 and stays free-running.
// u2 is a (4,2) instance used to probe the gate-closed low phase.
// Expected sequences are written out by hand from the counter trace of each instance.
module tb_gated_clock_div_prog;

  logic CLK_IN;
  logic RST;
  logic gate_a, gate_b, gate_c;
  logic pe0, co0, go0;
  logic pe1, co1, go1;
  logic pe2, co2, go2;

  int n_total;
  int n_bad;

  gated_clock_div_prog_if #(.width(4)) if0 ();
  gated_clock_div_prog_if #(.width(4)) if1 ();
  gated_clock_div_prog_if #(.width(4)) if2 ();

  gated_clock_div_prog #(.width(4), .DEF_DIV(3), .DEF_HIGH(1), .OFFSET(0)) u0 (
    .CLK_IN(CLK_IN), .RST(RST), .CLK_GATE_IN(gate_a), .cfg(if0),
    .PREEDGE(pe0), .CLK_OUT(co0), .CLK_GATE_OUT(go0)
  );

  gated_clock_div_prog #(.width(4), .DEF_DIV(3), .DEF_HIGH(1), .OFFSET(1)) u1 (
    .CLK_IN(CLK_IN), .RST(RST), .CLK_GATE_IN(gate_b), .cfg(if1),
    .PREEDGE(pe1), .CLK_OUT(co1), .CLK_GATE_OUT(go1)
  );

  gated_clock_div_prog #(.width(4), .DEF_DIV(4), .DEF_HIGH(2), .OFFSET(0)) u2 (
    .CLK_IN(CLK_IN), .RST(RST), .CLK_GATE_IN(gate_c), .cfg(if2),
    .PREEDGE(pe2), .CLK_OUT(co2), .CLK_GATE_OUT(go2)
  );

  // Hand-computed sequences, one entry per CLK_IN cycle, sampled at the falling edge.
  int e_a_co0 [6] = '{1, 0, 0, 1, 0, 0};
  int e_a_co1 [6] = '{0, 1, 0, 0, 1, 0};
  int e_a_pe0 [6] = '{0, 0, 1, 0, 0, 1};
  int e_b_co0 [5] = '{0, 0, 1, 1, 0};
  int e_b_pe0 [5] = '{0, 1, 0, 0, 0};
  int e_c_co0 [4] = '{0, 1, 1, 0};
  int e_d_co0 [7] = '{1, 1, 0, 0, 1, 1, 0};
  int e_d_pe0 [7] = '{0, 0, 0, 1, 0, 0, 0};
  int e_g_co0 [4] = '{0, 1, 1, 0};
  int e_r_co0 [3] = '{1, 0, 0};
  int e_r_co2 [3] = '{1, 1, 0};
`ifdef GATED_CLOCK_DIV_PROG_FREEZE_EN
  int e_f_pe2 [5] = '{0, 0, 0, 0, 0};
  int e_f_pe2_reopen = 0;
  int e_f_co2 [4] = '{0, 1, 1, 0};
`else
  int e_f_pe2 [5] = '{1, 0, 0, 0, 1};
  int e_f_pe2_reopen = 1;
  int e_f_co2 [4] = '{1, 1, 0, 0};
`endif

  // Clock: 10-unit period.
  initial CLK_IN = 1'b0;
  always #5 CLK_IN = ~CLK_IN;

  // Hard time limit so a broken design can never stall the run.
  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached before the summary");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK_IN);
    @(negedge CLK_IN);
  endtask

  task automatic cfg_write0(input logic [3:0] d, input logic [3:0] h);
    if0.DIV_IN  = d;
    if0.HIGH_IN = h;
    if0.CFG_EN  = 1'b1;
    tick();
    if0.CFG_EN  = 1'b0;
  endtask

  initial begin
    n_total = 0;
    n_bad   = 0;
    RST    = 1'b0;
    gate_a = 1'b1;
    gate_b = 1'b1;
    gate_c = 1'b1;
    if0.CFG_EN = 1'b0; if0.DIV_IN = '0; if0.HIGH_IN = '0;
    if1.CFG_EN = 1'b0; if1.DIV_IN = '0; if1.HIGH_IN = '0;
    if2.CFG_EN = 1'b0; if2.DIV_IN = '0; if2.HIGH_IN = '0;

    // Reset state.
    tick();
    tick();
    chk("rst_co0", co0, 0);
    chk("rst_go0", go0, 0);
    chk("rst_rdy0", if0.CFG_RDY, 1);
    chk("rst_err0", if0.CFG_ERR, 0);
    chk("rst_pe0", pe0, 0);
    chk("rst_co1", co1, 0);
    chk("rst_pe1", pe1, 0);
    chk("rst_co2", co2, 0);

    // Release reset. The gate latch opens, and u0 is one count before its first rise.
    RST = 1'b1;
    #1;
    chk("rel_pe0", pe0, 1);
    chk("rel_pe1", pe1, 0);
    chk("rel_go0", go0, 1);
    chk("rel_co0", co0, 0);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk($sformatf("def_co0_%0d", i), co0, e_a_co0[i]);
      chk($sformatf("off_co1_%0d", i), co1, e_a_co1[i]);
      chk($sformatf("def_pe0_%0d", i), pe0, e_a_pe0[i]);
    end

    // Mid-period write of (5,2). The old pulse completes, then the new pattern starts at the wrap.
    chk("w52_rdy_before", if0.CFG_RDY, 1);
    cfg_write0(4'd5, 4'd2);
    chk("w52_rdy_busy", if0.CFG_RDY, 0);
    chk("w52_old_pulse", co0, 1);
    chk("w52_pe_wrap", pe0, 0);
    tick();
    chk("w52_applied_co", co0, 0);
    chk("w52_rdy_back", if0.CFG_RDY, 1);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("p52_co0_%0d", i), co0, e_b_co0[i]);
      chk($sformatf("p52_pe0_%0d", i), pe0, e_b_pe0[i]);
    end

    // An illegal write (high == div) sets the error flag and leaves the pattern unchanged.
    cfg_write0(4'd4, 4'd4);
    chk("ill_err", if0.CFG_ERR, 1);
    chk("ill_rdy", if0.CFG_RDY, 1);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("ill_co0_%0d", i), co0, e_c_co0[i]);
    end

    // A legal (4,2) write clears the error flag. A write while busy is ignored.
    cfg_write0(4'd4, 4'd2);
    chk("leg_err_clr", if0.CFG_ERR, 0);
    chk("leg_rdy_busy", if0.CFG_RDY, 0);
    cfg_write0(4'd0, 4'd0);
    chk("busy_wr_err", if0.CFG_ERR, 0);
    chk("busy_wr_rdy", if0.CFG_RDY, 0);
    chk("busy_wr_co", co0, 0);
    for (int i = 0; i < 7; i++) begin
      tick();
      chk($sformatf("p42_co0_%0d", i), co0, e_d_co0[i]);
      chk($sformatf("p42_pe0_%0d", i), pe0, e_d_pe0[i]);
    end
    chk("p42_rdy", if0.CFG_RDY, 1);

    // Close the gate during the high phase. The pulse runs to full width, and the latch follows after the fall.
    tick();
    tick();
    chk("gate_hi_co", co0, 1);
    gate_a = 1'b0;
    #1;
    chk("gate_hold_go", go0, 1);
    chk("gate_hold_co", co0, 1);
    tick();
    chk("gate_hold2_co", co0, 1);
    chk("gate_hold2_go", go0, 1);
    tick();
    chk("gate_fall_co", co0, 0);
    chk("gate_fall_go", go0, 0);
    gate_a = 1'b1;
    #1;
    chk("gate_reopen_go", go0, 1);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("gate_co0_%0d", i), co0, e_g_co0[i]);
    end

    // Reset during the high phase with a write pending. The output drops at once, and the defaults return.
    tick();
    cfg_write0(4'd7, 4'd3);
    chk("mid_rdy_busy", if0.CFG_RDY, 0);
    chk("mid_co_high", co0, 1);
    #2;
    RST = 1'b0;
    #1;
    chk("mid_rst_co", co0, 0);
    chk("mid_rst_rdy", if0.CFG_RDY, 1);
    chk("mid_rst_pe", pe0, 0);
    chk("mid_rst_go", go0, 0);
    @(negedge CLK_IN);
    RST = 1'b1;
    #1;
    chk("rerel_pe0", pe0, 1);
    chk("rerel_pe2", pe2, 1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("rerel_co0_%0d", i), co0, e_r_co0[i]);
      chk($sformatf("rerel_co2_%0d", i), co2, e_r_co2[i]);
    end

    // u2 (4,2): close the gate for 5 cycles in the low phase, then reopen it.
    gate_c = 1'b0;
    #1;
    chk("frz_go2_closed", go2, 0);
    chk("frz_pe2_closed", pe2, 0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("frz_co2_%0d", i), co2, 0);
      chk($sformatf("frz_pe2_%0d", i), pe2, e_f_pe2[i]);
    end
    gate_c = 1'b1;
    #1;
    chk("frz_go2_open", go2, 1);
    chk("frz_pe2_open", pe2, e_f_pe2_reopen);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("frz_after_co2_%0d", i), co2, e_f_co2[i]);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
